seg_scan_driver: RTL and testbench

//   Time-multiplexed driver for the six-digit 7-segment panel of the washer front end.

---
 rtl/seg_scan_driver.sv | 141 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg_scan_driver                                                 |
// | Function : six-digit multiplexed 7-segment driver with frame-latched       |
// |            values, leading-zero blanking, shutDown blanking and pause      |
// |            blinking. Optional SEG_DP_STATE_EN lights dp in run/error.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       cp,
    input  logic       rst_n,
    input  logic [2:0] state,
    input  logic [5:0] showLeft,
    input  logic [5:0] showMiddle,
    input  logic [5:0] showRight,
    output logic [7:0] seg,
    output logic [5:0] an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [2:0] ST_SHUTDOWN = 3'd0;
    localparam logic [2:0] ST_PAUSE    = 3'd5;
`ifdef SEG_DP_STATE_EN
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_ERROR    = 3'd4;
`endif

    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       slot;
    logic [5:0]       shadow_left, shadow_middle, shadow_right;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_on;
    logic             slot_tick, frame_wrap;

    logic [5:0] value;
    logic [3:0] digit;
    logic       tens_slot, dark, dp_lit;
    logic [6:0] pattern;
    logic [5:0] an_next;
    logic [7:0] seg_next;

    assign slot_tick  = (scan_cnt == CNT_LAST);
    assign frame_wrap = slot_tick && (slot == 3'd0);

    // Scan restarts at slot 5 so every frame begins with the left tens digit.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            slot     <= 3'd5;
        end else if (slot_tick) begin
            scan_cnt <= '0;
            slot     <= (slot == 3'd0) ? 3'd5 : slot - 3'd1;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            shadow_left   <= '0;
            shadow_middle <= '0;
            shadow_right  <= '0;
        end else if (frame_wrap) begin
            shadow_left   <= showLeft;
            shadow_middle <= showMiddle;
            shadow_right  <= showRight;
        end
    end

    // Blink phase counts whole frames only while paused; any other state re-arms it lit.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (state != ST_PAUSE) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_wrap) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    always_comb begin
        value     = shadow_right;
        tens_slot = slot[0];
        pattern   = 7'b1111111;
        dp_lit    = 1'b0;
        case (slot)
            3'd5, 3'd4: value = shadow_left;
            3'd3, 3'd2: value = shadow_middle;
            default:    value = shadow_right;
        endcase
        digit = tens_slot ? 4'(value / 6'd10) : 4'(value % 6'd10);
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
`ifdef SEG_DP_STATE_EN
        dp_lit = ((state == ST_RUN) && (slot == 3'd3)) ||
                 ((state == ST_ERROR) && (slot == 3'd0));
`endif
        // State is used directly so leaving pause lights the panel on the next edge.
        dark = (state == ST_SHUTDOWN) ||
               ((state == ST_PAUSE) && !blink_on) ||
               (tens_slot && (digit == 4'd0));
        an_next  = dark ? 6'h3F : ~(6'd1 << slot);
        seg_next = dark ? 8'hFF : {~dp_lit, pattern};
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 6'h3F;
            seg <= 8'hFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seg_scan_driver                                              |
// | Function : randomized self-checking bench for seg_scan_driver against a    |
// |            cycle-count based reference model.                              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seg_scan_driver;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = 6 * SCAN_DIV;

    logic       cp;
    logic       rst_n;
    logic [2:0] state;
    logic [5:0] show_left, show_middle, show_right;
    logic [7:0] seg;
    logic [5:0] an;

    int tests;
    int fails;

    seg_scan_driver #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .cp         (cp),
        .rst_n      (rst_n),
        .state      (state),
        .showLeft   (show_left),
        .showMiddle (show_middle),
        .showRight  (show_right),
        .seg        (seg),
        .an         (an)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    function automatic logic [6:0] seven(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference: position in the scan derives from edges since reset (k); the
    // displayed value set is whatever was present at the last frame boundary.
    int         k;
    int         pause_wraps;
    logic [5:0] sh_l, sh_m, sh_r;
    logic [5:0] exp_an;
    logic [7:0] exp_seg;
    bit         exp_care;
    int         m_slot, m_val, m_dig;
    bit         m_tens, m_dark, m_dp, m_phase_on;

    always @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; pause_wraps = 0;
            sh_l = 0; sh_m = 0; sh_r = 0;
            exp_an = 6'h3F; exp_seg = 8'hFF; exp_care = 1;
        end else begin
            m_slot     = 5 - ((k / SCAN_DIV) % 6);
            m_val      = (m_slot >= 4) ? int'(sh_l) : (m_slot >= 2) ? int'(sh_m) : int'(sh_r);
            m_tens     = (m_slot % 2) == 1;
            m_dig      = m_tens ? m_val / 10 : m_val % 10;
            m_phase_on = ((pause_wraps / BLINK_FRAMES) % 2) == 0;
`ifdef SEG_DP_STATE_EN
            m_dp = (state == 3'd3 && m_slot == 3) || (state == 3'd4 && m_slot == 0);
`else
            m_dp = 0;
`endif
            m_dark   = (state == 3'd0) || (state == 3'd5 && !m_phase_on) || (m_tens && m_dig == 0);
            exp_an   = m_dark ? 6'h3F : ~(6'd1 << m_slot);
            exp_seg  = m_dark ? 8'hFF : {~m_dp, seven(m_dig)};
            exp_care = !m_dark || (state == 3'd0);
            if ((k % FRAME) == FRAME - 1) begin
                if (state == 3'd5) pause_wraps = pause_wraps + 1;
                sh_l = show_left; sh_m = show_middle; sh_r = show_right;
            end
            if (state != 3'd5) pause_wraps = 0;
            k = k + 1;
        end
    end

    task automatic test_reset();
        tests++;
        if (an !== 6'h3F || seg !== 8'hFF) begin
            fails++;
            $display("FAIL reset_hold: an=%h seg=%h expected an=3f seg=ff", an, seg);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                repeat (6) @(negedge cp);
                #2 rst_n = 1'b0;
                #1;
                tests++;
                if (an !== 6'h3F || seg !== 8'hFF) begin
                    fails++;
                    $display("FAIL reset_async: an=%h seg=%h expected an=3f seg=ff", an, seg);
                end
            end
            @(negedge cp);
            rst_n = 1'b1;
            // Shadow values are zero: slot 5 is a blanked leading zero, slot 4 shows '0'.
            for (int j = 1; j <= SCAN_DIV + 1; j++) begin
                @(negedge cp);
                tests++;
                if (j <= SCAN_DIV && an !== 6'h3F) begin
                    fails++;
                    $display("FAIL reset_first_slot: sample %0d an=%h expected an=3f", j, an);
                end else if (j == SCAN_DIV + 1 && (an !== 6'h2F || seg !== 8'hC0)) begin
                    fails++;
                    $display("FAIL reset_slot4: an=%h seg=%h expected an=2f seg=c0", an, seg);
                end
            end
        end
    endtask

    task automatic test_digits();
        int n_lt, n_mt;
        n_lt = 0; n_mt = 0;
        state = 3'd1; show_left = 6'd42; show_middle = 6'd7; show_right = 6'd0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge cp);
            tests++;
            if (an !== exp_an || (exp_care && seg !== exp_seg)) begin
                fails++;
                $display("FAIL digits: an=%h seg=%h expected an=%h seg=%h", an, seg, exp_an, exp_seg);
            end
            if (i >= 2 * FRAME && an === 6'h1F && seg === 8'h99) n_lt++;
            if (i >= 2 * FRAME && an === 6'h37) n_mt++;
        end
        tests++;
        if (n_lt != SCAN_DIV || n_mt != 0) begin
            fails++;
            $display("FAIL digits_42_7: left-tens cycles=%0d mid-tens cycles=%0d expected %0d and 0", n_lt, n_mt, SCAN_DIV);
        end
    endtask

    task automatic test_full_range();
        int n6, n3;
        n6 = 0; n3 = 0;
        state = 3'd1; show_left = 6'd63;
        show_middle = 6'($urandom_range(63, 0)); show_right = 6'($urandom_range(63, 0));
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge cp);
            tests++;
            if (an !== exp_an || (exp_care && seg !== exp_seg)) begin
                fails++;
                $display("FAIL full_range: an=%h seg=%h expected an=%h seg=%h", an, seg, exp_an, exp_seg);
            end
            if (i >= 2 * FRAME && an === 6'h1F) n6 += (seg === 8'h82) ? 1 : 100;
            if (i >= 2 * FRAME && an === 6'h2F) n3 += (seg === 8'hB0) ? 1 : 100;
        end
        tests++;
        if (n6 != SCAN_DIV || n3 != SCAN_DIV) begin
            fails++;
            $display("FAIL full_range_63: slot5 score=%0d slot4 score=%0d expected %0d each", n6, n3, SCAN_DIV);
        end
    endtask

    task automatic test_mid_frame();
        int n_new, n_old, guard;
        n_new = 0; n_old = 0; guard = 0;
        state = 3'd1; show_left = 6'd42;
        repeat (2 * FRAME) @(negedge cp);
        while (an !== 6'h2F && guard < 2 * FRAME) begin
            @(negedge cp);
            guard++;
        end
        tests++;
        if (guard >= 2 * FRAME) begin
            fails++;
            $display("FAIL mid_frame_sync: slot 4 not seen, an=%h expected an=2f", an);
        end
        show_left = 6'd15;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge cp);
            tests++;
            if (an !== exp_an || (exp_care && seg !== exp_seg)) begin
                fails++;
                $display("FAIL mid_frame: an=%h seg=%h expected an=%h seg=%h", an, seg, exp_an, exp_seg);
            end
            if (an === 6'h1F && seg === 8'hF9) n_new++;
            if (an === 6'h1F && seg === 8'h99) n_old++;
        end
        tests++;
        if (n_new != SCAN_DIV || n_old != 0) begin
            fails++;
            $display("FAIL mid_frame_latch: new-tens cycles=%0d old-tens cycles=%0d expected %0d and 0", n_new, n_old, SCAN_DIV);
        end
    endtask

    task automatic test_pause();
        int guard;
        guard = 0;
        state = 3'd1; show_left = 6'd42; show_middle = 6'd15; show_right = 6'd33;
        repeat (FRAME + int'($urandom_range(FRAME - 1, 0))) @(negedge cp);
        state = 3'd5;
        for (int i = 0; i < 10 * FRAME; i++) begin
            @(negedge cp);
            tests++;
            if (an !== exp_an || (exp_care && seg !== exp_seg)) begin
                fails++;
                $display("FAIL pause_blink: an=%h seg=%h expected an=%h seg=%h", an, seg, exp_an, exp_seg);
            end
        end
        while (exp_an !== 6'h3F && guard < 4 * FRAME) begin
            @(negedge cp);
            guard++;
        end
        state = 3'd3;
        @(negedge cp);
        tests++;
        if (guard >= 4 * FRAME || an === 6'h3F) begin
            fails++;
            $display("FAIL pause_exit: an=%h expected a lit anode (wait=%0d)", an, guard);
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge cp);
            tests++;
            if (an !== exp_an || (exp_care && seg !== exp_seg)) begin
                fails++;
                $display("FAIL pause_after: an=%h seg=%h expected an=%h seg=%h", an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_shutdown();
        state = 3'd0;
        show_left = 6'($urandom_range(63, 10)); show_right = 6'($urandom_range(63, 10));
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge cp);
            tests++;
            if (an !== exp_an || seg !== exp_seg) begin
                fails++;
                $display("FAIL shutdown: an=%h seg=%h expected an=%h seg=%h", an, seg, exp_an, exp_seg);
            end
        end
        state = 3'd4;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge cp);
            tests++;
            if (an !== exp_an || (exp_care && seg !== exp_seg)) begin
                fails++;
                $display("FAIL error_state: an=%h seg=%h expected an=%h seg=%h", an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            state       = 3'($urandom_range(6, 0));
            show_left   = 6'($urandom_range(63, 0));
            show_middle = 6'($urandom_range(63, 0));
            show_right  = 6'($urandom_range(63, 0));
            repeat (int'($urandom_range(60, 1))) begin
                @(negedge cp);
                tests++;
                if (an !== exp_an || (exp_care && seg !== exp_seg)) begin
                    fails++;
                    $display("FAIL random st=%0d: an=%h seg=%h expected an=%h seg=%h", state, an, seg, exp_an, exp_seg);
                end
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; state = 3'd1;
        show_left = '0; show_middle = '0; show_right = '0;
        repeat (3) @(negedge cp);
        test_reset();
        test_digits();
        test_full_range();
        test_mid_frame();
        test_pause();
        test_shutdown();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
